// File: rtl/ucie_ctl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ucie_ctl_pkg
//  Purpose  : Shared types and constants for the UCIe controller TX path.
//             - state_e           : serializer state (IDLE / SEND)
//             - RDI_STATE_ACTIVE  : RDI pl_state_sts encoding of Active
//             - WORD_CNT_W        : width of the transmitted-word counter
//             - cnt_width()       : beat counter width for a given ratio
//  Revision : 1.0  initial release
// ============================================================================
package ucie_ctl_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [3:0] RDI_STATE_ACTIVE = 4'b0001;
  localparam int         WORD_CNT_W       = 16;

  // A ratio of 1 still needs a 1-bit counter so every vector stays legal.
  function automatic int cnt_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ucie_ctl_tx_beat_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : ucie_ctl_tx_beat_ctr
//  Purpose  : Beat index counter for the TX serializer. Counts 0..RATIO-1,
//             wrapping to 0 when incremented on the last beat.
//  Ports    : i_clk    - clock
//             i_rst    - synchronous active-low reset
//             i_inc    - advance one beat
//             i_clear  - force index to 0 (priority over i_inc)
//             o_cnt    - current beat index
//             o_last   - current beat is the last beat of the word
//  Revision : 1.0  initial release
// ============================================================================
module ucie_ctl_tx_beat_ctr
  import ucie_ctl_pkg::*;
#(
  parameter int RATIO = 4,
  parameter int CNT_W = cnt_width(RATIO)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign o_cnt  = cnt_q;
  assign o_last = (cnt_q == LAST_IDX);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_inc) begin
      // Wrapping on the last beat leaves the index at 0 both for a
      // back-to-back reload and for the return to IDLE.
      cnt_d = o_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ucie_ctl_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : ucie_ctl_tx_serializer
//  Purpose  : Splits IN_WIDTH words from the TX FIFO into RATIO beats of
//             OUT_WIDTH on the RDI lp_data bus (beat 0 = LSBs). Traffic is
//             gated on RDI Active; losing Active mid-word drops the word and
//             pulses o_abort_err. Counts completed words (16-bit, wrapping).
//  Ports    : i_clk, i_rst (sync active-low)
//             i_rdi_pl_state_sts          - RDI link state
//             i_tx_valid/i_tx_irdy/i_tx_data, o_tx_trdy - upstream word hs
//             o_rdi_lp_valid/o_rdi_lp_irdy/o_rdi_lp_data, i_rdi_pl_trdy
//                                         - RDI beat handshake
//             o_busy        - word in flight
//             o_abort_err   - one-cycle pulse after a dropped word
//             o_tx_word_cnt - completed word count
//  Revision : 1.0  initial release
// ============================================================================
`ifndef TX_WIDTH
`define TX_WIDTH 256
`endif

module ucie_ctl_tx_serializer
  import ucie_ctl_pkg::*;
#(
  parameter int IN_WIDTH  = `TX_WIDTH,
  parameter int OUT_WIDTH = 64,
  parameter int RATIO     = IN_WIDTH / OUT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [3:0]            i_rdi_pl_state_sts,
  input  logic                  i_tx_valid,
  input  logic                  i_tx_irdy,
  input  logic [IN_WIDTH-1:0]   i_tx_data,
  output logic                  o_tx_trdy,
  output logic                  o_rdi_lp_valid,
  output logic                  o_rdi_lp_irdy,
  output logic [OUT_WIDTH-1:0]  o_rdi_lp_data,
  input  logic                  i_rdi_pl_trdy,
  output logic                  o_busy,
  output logic                  o_abort_err,
  output logic [WORD_CNT_W-1:0] o_tx_word_cnt
);

  localparam int CNT_W = cnt_width(RATIO);

  state_e                state_q,     state_d;
  logic [IN_WIDTH-1:0]   data_q,      data_d;
  logic [WORD_CNT_W-1:0] word_cnt_q,  word_cnt_d;
  logic                  abort_err_q, abort_err_d;

  logic [CNT_W-1:0]      beat_cnt;
  logic                  beat_last;
  logic [OUT_WIDTH-1:0]  beat_data;

  logic active;
  logic busy;
  logic lp_valid;
  logic beat_hs;
  logic word_done;
  logic accept;
  logic abort;
  logic tx_trdy;

  assign active   = (i_rdi_pl_state_sts == RDI_STATE_ACTIVE);
  assign busy     = (state_q == SEND);
  assign lp_valid = busy & active;
  assign beat_hs  = lp_valid & i_rdi_pl_trdy;
  assign word_done = beat_hs & beat_last;
  assign abort    = busy & ~active;

  // Ready in IDLE, or on the final beat when RDI takes it, so the next word
  // loads with no bubble. Held low while reset is asserted so no word can be
  // accepted against a design that is being cleared.
  assign tx_trdy = i_rst & active & (~busy | (beat_last & i_rdi_pl_trdy));
  assign accept  = i_tx_valid & i_tx_irdy & tx_trdy;

  ucie_ctl_tx_beat_ctr #(
    .RATIO (RATIO),
    .CNT_W (CNT_W)
  ) u_beat_ctr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (beat_hs),
    .i_clear (abort | (accept & ~busy)),
    .o_cnt   (beat_cnt),
    .o_last  (beat_last)
  );

  // Beat selection: a plain slice when each word is a single beat, otherwise
  // an indexed mux over the held word.
  if (RATIO == 1) begin : g_ratio_one
    assign beat_data = data_q[OUT_WIDTH-1:0];
  end else begin : g_ratio_multi
    logic [OUT_WIDTH-1:0] beats [RATIO];
    for (genvar i = 0; i < RATIO; i++) begin : g_beat
      assign beats[i] = data_q[i*OUT_WIDTH +: OUT_WIDTH];
    end
    assign beat_data = beats[beat_cnt];
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    word_cnt_d  = word_cnt_q;
    abort_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          data_d  = i_tx_data;
        end
      end
      SEND: begin
        if (abort) begin
          // Link loss wins over a coincident last beat: nothing completes.
          state_d     = IDLE;
          data_d      = '0;
          abort_err_d = 1'b1;
        end else if (word_done) begin
          word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
          if (accept) begin
            data_d = i_tx_data;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      word_cnt_q  <= '0;
      abort_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      word_cnt_q  <= word_cnt_d;
      abort_err_q <= abort_err_d;
    end
  end

  assign o_tx_trdy      = tx_trdy;
  assign o_rdi_lp_valid = lp_valid;
  assign o_rdi_lp_irdy  = lp_valid;
  assign o_rdi_lp_data  = busy ? beat_data : '0;
  assign o_busy         = busy;
  assign o_abort_err    = abort_err_q;
  assign o_tx_word_cnt  = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ucie_ctl_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ucie_ctl_tx_serializer
//  Purpose  : Directed self-checking bench for ucie_ctl_tx_serializer with
//             IN_WIDTH=256, OUT_WIDTH=64 (RATIO=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ucie_ctl_tx_serializer;

  localparam int IN_W  = 256;
  localparam int OUT_W = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       sts;
  logic             tx_valid;
  logic             tx_irdy;
  logic [IN_W-1:0]  tx_data;
  logic             tx_trdy;
  logic             lp_valid;
  logic             lp_irdy;
  logic [OUT_W-1:0] lp_data;
  logic             pl_trdy;
  logic             busy;
  logic             abort_err;
  logic [15:0]      word_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ucie_ctl_tx_serializer #(
    .IN_WIDTH  (IN_W),
    .OUT_WIDTH (OUT_W)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst_n),
    .i_rdi_pl_state_sts (sts),
    .i_tx_valid         (tx_valid),
    .i_tx_irdy          (tx_irdy),
    .i_tx_data          (tx_data),
    .o_tx_trdy          (tx_trdy),
    .o_rdi_lp_valid     (lp_valid),
    .o_rdi_lp_irdy      (lp_irdy),
    .o_rdi_lp_data      (lp_data),
    .i_rdi_pl_trdy      (pl_trdy),
    .o_busy             (busy),
    .o_abort_err        (abort_err),
    .o_tx_word_cnt      (word_cnt)
  );

  // Word whose beat b carries the 64-bit value base+b.
  function automatic logic [IN_W-1:0] mk_word(input logic [63:0] base);
    return {base + 64'd3, base + 64'd2, base + 64'd1, base};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the beat-side outputs of a cycle in SEND.
  task automatic chk_beat(input string tag, input logic [63:0] exp_data, input logic exp_trdy);
    #1;
    chk({tag, "_valid"}, 64'(lp_valid), 64'd1);
    chk({tag, "_irdy"},  64'(lp_irdy),  64'd1);
    chk({tag, "_data"},  lp_data,       exp_data);
    chk({tag, "_trdy"},  64'(tx_trdy),  64'(exp_trdy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    sts      = 4'b0001;
    tx_valid = 1'b0;
    tx_irdy  = 1'b0;
    tx_data  = '0;
    pl_trdy  = 1'b1;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_trdy",   64'(tx_trdy),   64'd0);
    chk("rst_valid",  64'(lp_valid),  64'd0);
    chk("rst_irdy",   64'(lp_irdy),   64'd0);
    chk("rst_data",   lp_data,        64'd0);
    chk("rst_busy",   64'(busy),      64'd0);
    chk("rst_abort",  64'(abort_err), 64'd0);
    chk("rst_cnt",    64'(word_cnt),  64'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_trdy",  64'(tx_trdy),   64'd1);

    // ---------------- single word ----------------
    tx_valid = 1'b1;
    tx_irdy  = 1'b1;
    tx_data  = mk_word(64'h0);
    tick();
    tx_valid = 1'b0;
    chk_beat("w1_b0", 64'h0, 1'b0); tick();
    chk_beat("w1_b1", 64'h1, 1'b0); tick();
    chk_beat("w1_b2", 64'h2, 1'b0); tick();
    chk_beat("w1_b3", 64'h3, 1'b1); tick();
    chk("w1_busy", 64'(busy),     64'd0);
    chk("w1_cnt",  64'(word_cnt), 64'd1);
    chk("w1_lpv",  64'(lp_valid), 64'd0);

    // ---------------- three back-to-back words ----------------
    tx_valid = 1'b1;
    tx_data  = mk_word(64'h100);
    tick();
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 3) begin
        if (i / 4 < 2) tx_data = mk_word(64'h100 * (i / 4 + 2));
        else           tx_valid = 1'b0;
      end
      chk_beat($sformatf("b2b_%0d", i), 64'h100 * (i / 4 + 1) + 64'(i % 4), (i % 4) == 3);
      tick();
    end
    chk("b2b_busy", 64'(busy),     64'd0);
    chk("b2b_cnt",  64'(word_cnt), 64'd4);

    // ---------------- RDI stall on beat 2 ----------------
    tx_valid = 1'b1;
    tx_data  = mk_word(64'h400);
    tick();
    tx_valid = 1'b0;
    chk_beat("st_b0", 64'h400, 1'b0); tick();
    chk_beat("st_b1", 64'h401, 1'b0); tick();
    pl_trdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_beat($sformatf("st_hold%0d", i), 64'h402, 1'b0);
      tick();
    end
    pl_trdy = 1'b1;
    chk_beat("st_b2", 64'h402, 1'b0); tick();
    chk("st_cnt_mid", 64'(word_cnt), 64'd4);
    chk_beat("st_b3", 64'h403, 1'b1); tick();
    chk("st_busy", 64'(busy),     64'd0);
    chk("st_cnt",  64'(word_cnt), 64'd5);

    // ---------------- link loss on beat 1 ----------------
    tx_valid = 1'b1;
    tx_data  = mk_word(64'h500);
    tick();
    tx_valid = 1'b0;
    chk_beat("ab_b0", 64'h500, 1'b0); tick();
    sts = 4'b0011;
    #1;
    chk("ab_lpv",   64'(lp_valid),  64'd0);
    chk("ab_lpi",   64'(lp_irdy),   64'd0);
    chk("ab_trdy",  64'(tx_trdy),   64'd0);
    chk("ab_busy",  64'(busy),      64'd1);
    tick();
    chk("ab_pulse", 64'(abort_err), 64'd1);
    chk("ab_idle",  64'(busy),      64'd0);
    chk("ab_cnt",   64'(word_cnt),  64'd5);
    tx_valid = 1'b1;
    tx_data  = mk_word(64'h600);
    #1;
    chk("ab_idle_trdy", 64'(tx_trdy), 64'd0);
    tick();
    chk("ab_pulse_end", 64'(abort_err), 64'd0);
    chk("ab_no_accept", 64'(busy),      64'd0);
    sts = 4'b0001;
    tick();
    tx_valid = 1'b0;
    chk_beat("re_b0", 64'h600, 1'b0); tick();
    chk_beat("re_b1", 64'h601, 1'b0); tick();
    chk_beat("re_b2", 64'h602, 1'b0); tick();
    chk_beat("re_b3", 64'h603, 1'b1); tick();
    chk("re_cnt", 64'(word_cnt), 64'd6);

    // ---------------- link loss coincident with last beat ----------------
    tx_valid = 1'b1;
    tx_data  = mk_word(64'h700);
    tick();
    tx_valid = 1'b0;
    tick(); tick(); tick();
    sts = 4'b0000;
    tx_valid = 1'b1;
    #1;
    chk("ll_trdy",  64'(tx_trdy),   64'd0);
    chk("ll_lpv",   64'(lp_valid),  64'd0);
    tick();
    tx_valid = 1'b0;
    chk("ll_pulse", 64'(abort_err), 64'd1);
    chk("ll_cnt",   64'(word_cnt),  64'd6);
    chk("ll_idle",  64'(busy),      64'd0);
    sts = 4'b0001;

    // ---------------- word counter wrap ----------------
    force dut.word_cnt_q = 16'hFFFF;
    #1;
    release dut.word_cnt_q;
    tick();
    chk("wr_pre", 64'(word_cnt), 64'hFFFF);
    tx_valid = 1'b1;
    tx_data  = mk_word(64'h800);
    tick();
    tx_valid = 1'b0;
    tick(); tick(); tick();
    chk("wr_mid", 64'(word_cnt), 64'hFFFF);
    tick();
    chk("wr_wrap", 64'(word_cnt), 64'h0000);

    // ---------------- reset mid-word ----------------
    tx_valid = 1'b1;
    tx_data  = mk_word(64'h900);
    tick();
    tx_valid = 1'b0;
    tick();
    chk_beat("rm_b1", 64'h901, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("rm_trdy",  64'(tx_trdy),   64'd0);
    chk("rm_valid", 64'(lp_valid),  64'd0);
    chk("rm_irdy",  64'(lp_irdy),   64'd0);
    chk("rm_data",  lp_data,        64'd0);
    chk("rm_busy",  64'(busy),      64'd0);
    chk("rm_abort", 64'(abort_err), 64'd0);
    chk("rm_cnt",   64'(word_cnt),  64'd0);
    rst_n = 1'b1;
    tick();
    chk("rm_abort2", 64'(abort_err), 64'd0);
    chk("rm_busy2",  64'(busy),      64'd0);
    chk("rm_cnt2",   64'(word_cnt),  64'd0);
    chk("rm_trdy2",  64'(tx_trdy),   64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
